// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 core: shifts in XOR/mux key bits plus an even-parity bit
// and commits the key on a parity match. Optional lockout after MAX_FAIL failures: C432_KEY_LOCKOUT_EN.
module c432_key_loader #(
  parameter int XOR_W    = 26,
  parameter int MUX_W    = 4,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_valid,
  input  logic             key_sdi,
  input  logic             key_clr,
  output logic [XOR_W-1:0] key_xor,
  output logic [MUX_W-1:0] key_mux,
  output logic             key_ok,
  output logic             load_done,
  output logic             load_err,
  output logic             busy,
  output logic             locked_out
);
  localparam int KEY_W = XOR_W + MUX_W;
  localparam int CW    = $clog2(KEY_W);
  localparam int FW    = $clog2(MAX_FAIL + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t             r_state, w_next;
  logic [KEY_W-1:0]   r_shadow;
  logic [CW-1:0]      r_cnt;
  logic [FW-1:0]      r_fail;
  logic [XOR_W-1:0]   r_key_xor;
  logic [MUX_W-1:0]   r_key_mux;
  logic               r_key_ok, r_done, r_err;
  logic               w_start, w_accept, w_commit, w_fail, w_par_ok, w_locked, w_trip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Restart always wins over data/parity in the same cycle; its key_valid is dropped.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_accept = 1'b0;
    w_commit = 1'b0;
    w_fail   = 1'b0;
    w_par_ok = ~(^r_shadow ^ key_sdi);
    case (r_state)
      IDLE: begin
        if (load_start && !w_locked) begin
          w_start = 1'b1;
          w_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (load_start) begin
          w_start = 1'b1;
        end else if (key_valid) begin
          w_accept = 1'b1;
          if (r_cnt == CW'(KEY_W - 1)) w_next = PARITY;
        end
      end
      PARITY: begin
        if (load_start) begin
          w_start = 1'b1;
          w_next  = SHIFT;
        end else if (key_valid) begin
          w_next   = IDLE;
          w_commit = w_par_ok;
          w_fail   = ~w_par_ok;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_cnt    <= '0;
    end else if (w_start) begin
      r_shadow <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_shadow[r_cnt] <= key_sdi;
      r_cnt           <= r_cnt + 1'b1;
    end
  end

  // Failure counter saturates; it only has an effect when lockout is built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_fail <= '0;
    else if (w_commit)                             r_fail <= '0;
    else if (w_fail && (r_fail != FW'(MAX_FAIL)))  r_fail <= r_fail + 1'b1;
  end

`ifdef C432_KEY_LOCKOUT_EN
  logic r_locked;
  assign w_trip   = w_fail && (r_fail == FW'(MAX_FAIL - 1));
  assign w_locked = r_locked;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_locked <= 1'b0;
    else if (w_trip) r_locked <= 1'b1;
  end
`else
  assign w_trip   = 1'b0;
  assign w_locked = 1'b0;
`endif

  // Clear (explicit or lockout) beats a same-cycle commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_xor <= '0;
      r_key_mux <= '0;
      r_key_ok  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= w_commit;
      r_err  <= w_fail;
      if (w_trip || key_clr) begin
        r_key_xor <= '0;
        r_key_mux <= '0;
        r_key_ok  <= 1'b0;
      end else if (w_commit) begin
        r_key_xor <= r_shadow[XOR_W-1:0];
        r_key_mux <= r_shadow[KEY_W-1:XOR_W];
        r_key_ok  <= 1'b1;
      end
    end
  end

  assign key_xor    = r_key_xor;
  assign key_mux    = r_key_mux;
  assign key_ok     = r_key_ok;
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign busy       = (r_state != IDLE);
  assign locked_out = w_locked;
endmodule

// File: tb/tb_c432_key_loader.sv
// Directed bench for c432_key_loader: frame table plus abort, key_clr and lockout/retry sequences.
module tb_c432_key_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_start = 1'b0, key_valid = 1'b0, key_sdi = 1'b0, key_clr = 1'b0;
  logic [25:0] key_xor;
  logic [3:0]  key_mux;
  logic        key_ok, load_done, load_err, busy, locked_out;

  int n_cmp = 0;
  int n_bad = 0;

  c432_key_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_valid(key_valid),
    .key_sdi(key_sdi), .key_clr(key_clr), .key_xor(key_xor), .key_mux(key_mux),
    .key_ok(key_ok), .load_done(load_done), .load_err(load_err), .busy(busy),
    .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] x;
    logic [3:0]  m;
    bit          bad;
    bit          clr;
    bit          gap;
    logic [25:0] ex;
    logic [3:0]  em;
    bit          eok;
    bit          edone;
    bit          eerr;
    int          elat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drives one frame: start pulse (with a stray key_valid that must be dropped),
  // 30 data bits, then parity, optionally with an idle cycle before every bit.
  task automatic send_frame(input vec_t v, input bit exp_busy);
    logic [29:0] f;
    int lat;
    f = {v.m, v.x};
    load_start = 1'b1; key_valid = 1'b1; key_sdi = 1'b1;
    tick();
    lat = 1;
    load_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(exp_busy));
    chk("no_pulse_at_start", 32'({load_done, load_err}), 32'd0);
    for (int k = 0; k < 31; k++) begin
      if (v.gap) begin
        key_valid = 1'b0;
        tick();
        lat++;
      end
      key_valid = 1'b1;
      key_sdi   = (k < 30) ? f[k] : ((^f) ^ v.bad);
      key_clr   = (k == 30) ? v.clr : 1'b0;
      tick();
      lat++;
      if (k < 30) chk("busy_in_frame", 32'(busy), 32'(exp_busy));
    end
    key_valid = 1'b0; key_clr = 1'b0;
    chk("key_xor", 32'(key_xor), 32'(v.ex));
    chk("key_mux", 32'(key_mux), 32'(v.em));
    chk("key_ok", 32'(key_ok), 32'(v.eok));
    chk("load_done", 32'(load_done), 32'(v.edone));
    chk("load_err", 32'(load_err), 32'(v.eerr));
    if (v.elat != 0) chk("latency", 32'(lat), 32'(v.elat));
    tick();
    chk("pulse_drop", 32'({load_done, load_err, busy}), 32'd0);
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    tbl[0] = '{26'h2A5_5A5A, 4'b1010, 0, 0, 0, 26'h2A5_5A5A, 4'b1010, 1, 1, 0, 32};
    tbl[1] = '{26'h0000001,  4'h1,    0, 0, 0, 26'h0000001,  4'h1,    1, 1, 0, 32};
    tbl[2] = '{26'h3FF_FFFF, 4'hF,    1, 0, 0, 26'h0000001,  4'h1,    1, 0, 1, 32};
    tbl[3] = '{26'h0F0_F0F0, 4'h9,    0, 0, 1, 26'h0F0_F0F0, 4'h9,    1, 1, 0, 63};
    tbl[4] = '{26'h0AB_CDEF, 4'h5,    0, 1, 0, 26'h0,        4'h0,    0, 1, 0, 32};
    tbl[5] = '{26'h155_5555, 4'h6,    0, 0, 0, 26'h155_5555, 4'h6,    1, 1, 0, 32};

    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_outputs", 32'({key_xor, key_ok, load_done, load_err, busy, locked_out}), 32'd0);
    chk("rst_mux", 32'(key_mux), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) send_frame(tbl[i], 1'b1);

    // Abort after 10 bits, then a full frame: only the second one commits.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      key_valid = 1'b1; key_sdi = k[0];
      tick();
    end
    key_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    v = '{26'h1234567, 4'h3, 0, 0, 0, 26'h1234567, 4'h3, 1, 1, 0, 32};
    send_frame(v, 1'b1);

`ifdef C432_KEY_LOCKOUT_EN
    for (int i = 0; i < 3; i++) begin
      v = '{26'h3000000, 4'hC, 1, 0, 0, 26'h1234567, 4'h3, 1, 0, 1, 32};
      if (i == 2) begin v.ex = '0; v.em = '0; v.eok = 0; end
      send_frame(v, 1'b1);
      chk("locked_out", 32'(locked_out), 32'(i == 2));
    end
    v = '{26'h2222222, 4'h2, 0, 0, 0, 26'h0, 4'h0, 0, 0, 0, 0};
    send_frame(v, 1'b0);
    chk("still_locked", 32'(locked_out), 32'd1);
    #2 rst_n = 1'b0;
    #2;
    chk("async_unlock", 32'({locked_out, key_ok}), 32'd0);
    rst_n = 1'b1;
    tick();
    v = '{26'h2222222, 4'h2, 0, 0, 0, 26'h2222222, 4'h2, 1, 1, 0, 32};
    send_frame(v, 1'b1);
`else
    for (int i = 0; i < 4; i++) begin
      v = '{26'h3000000, 4'hC, 1, 0, 0, 26'h1234567, 4'h3, 1, 0, 1, 32};
      send_frame(v, 1'b1);
      chk("no_lockout", 32'(locked_out), 32'd0);
    end
    v = '{26'h2222222, 4'h2, 0, 0, 0, 26'h2222222, 4'h2, 1, 1, 0, 32};
    send_frame(v, 1'b1);
`endif

    // key_clr alone clears the committed key without touching the FSM.
    key_clr = 1'b1;
    tick();
    key_clr = 1'b0;
    chk("clr_key", 32'({key_xor, key_mux, key_ok}), 32'd0);
    chk("clr_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
